timer_access_ctrl: RTL and testbench

Sequences all CPU accesses to the 60 Hz delay/sound timer block and drives the audio tone. It converts single-cycle CPU requests (read delay, write delay, write sound, wait-for-delay-zero) into correctly timed set strobes and data for the timers, and returns a one-cycle acknowledge. It also generates a square-wave beep whenever the sound timer is non-zero. It sits between the CPU core and the timers block.

---
 rtl/timer_access_ctrl_if.sv | 20 ++
 rtl/timer_access_ctrl.sv | 125 ++++++++++++
 tb/tb_timer_access_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_access_ctrl_if.sv
// CPU-side request/acknowledge bundle for timer_access_ctrl.
// The CPU is the master; the access controller is the slave.
interface timer_access_ctrl_if;
    logic       req;
    logic [1:0] op;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;
    logic       busy;

    modport master (
        output req, op, wdata,
        input  ack, rdata, busy
    );

    modport slave (
        input  req, op, wdata,
        output ack, rdata, busy
    );
endinterface

// File: rtl/timer_access_ctrl.sv
// Sequences CPU accesses to the 60 Hz delay/sound timers
// and generates the square-wave beep while sound is active.
module timer_access_ctrl #(
    parameter int unsigned TONE_HALF_PERIOD = 56818
) (
    input  logic                clk,
    input  logic                rst,
    timer_access_ctrl_if.slave  cpu,
    output logic [7:0]          timer_data,
    output logic                set_delay,
    output logic                set_sound,
    input  logic [7:0]          delay_timer,
    input  logic [7:0]          sound_timer,
    output logic                beep
);

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WD = 2'b01;
    localparam logic [1:0] OP_WS = 2'b10;
    localparam logic [1:0] OP_WT = 2'b11;

    localparam logic [19:0] TONE_LAST = 20'(TONE_HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic [19:0] r_tone_cnt;
    logic        r_beep;
    logic        w_accept;
    logic        w_delay_zero;
    logic        w_sound_on;

    assign w_accept     = (r_state == S_IDLE) && cpu.req;
    assign w_delay_zero = (delay_timer == 8'd0);
    assign w_sound_on   = (sound_timer != 8'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cpu.req) begin
                    case (cpu.op)
                        OP_RD:   w_next = S_READ;
                        OP_WT:   w_next = S_WAIT;
                        default: w_next = S_WRITE;
                    endcase
                end
            end
            S_WRITE: w_next = S_ACK;
            S_READ:  w_next = S_ACK;
            S_WAIT:  if (w_delay_zero) w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs; strobes only exist in WRITE
    always_comb begin
        cpu.ack   = (r_state == S_ACK);
        cpu.busy  = (r_state != S_IDLE);
        set_delay = (r_state == S_WRITE) && (r_op == OP_WD);
        set_sound = (r_state == S_WRITE) && (r_op == OP_WS);
    end

    // Capture the request only when accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= 2'b00;
            r_wdata <= 8'h00;
        end else if (w_accept) begin
            r_op    <= cpu.op;
            r_wdata <= cpu.wdata;
        end
    end

    // Read result: timer sample on READ exit, zero on WAIT exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 8'h00;
        end else if (r_state == S_READ) begin
            r_rdata <= delay_timer;
        end else if ((r_state == S_WAIT) && w_delay_zero) begin
            r_rdata <= 8'h00;
        end
    end

    assign cpu.rdata  = r_rdata;
    assign timer_data = r_wdata;

    // Tone divider; held cleared while the sound timer is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tone_cnt <= 20'd0;
            r_beep     <= 1'b0;
        end else if (!w_sound_on) begin
            r_tone_cnt <= 20'd0;
            r_beep     <= 1'b0;
        end else if (r_tone_cnt == TONE_LAST) begin
            r_tone_cnt <= 20'd0;
            r_beep     <= ~r_beep;
        end else begin
            r_tone_cnt <= r_tone_cnt + 20'd1;
        end
    end

    assign beep = r_beep;

endmodule

// File: tb/tb_timer_access_ctrl.sv
// Directed bench for timer_access_ctrl with a small timers model.
// Inputs change on negedge; outputs are checked on negedge.
module tb_timer_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] timer_data;
    logic       set_delay;
    logic       set_sound;
    logic [7:0] d_tmr = 8'h00;
    logic [7:0] s_tmr = 8'h00;
    logic       beep;

    logic       ld_d;
    logic       ld_s;
    logic       dec_d;
    logic [7:0] ld_val;

    int checks = 0;
    int errors = 0;

    timer_access_ctrl_if bus ();

    timer_access_ctrl #(.TONE_HALF_PERIOD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (bus),
        .timer_data  (timer_data),
        .set_delay   (set_delay),
        .set_sound   (set_sound),
        .delay_timer (d_tmr),
        .sound_timer (s_tmr),
        .beep        (beep)
    );

    always #5 clk = ~clk;

    // Timers block model: CPU load wins over tb load and decrement
    always @(posedge clk) begin
        if (set_delay)               d_tmr <= timer_data;
        else if (ld_d)               d_tmr <= ld_val;
        else if (dec_d && d_tmr != 0) d_tmr <= d_tmr - 8'd1;
        if (set_sound)               s_tmr <= timer_data;
        else if (ld_s)               s_tmr <= ld_val;
    end

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b ack=%b want 0 0", bus.busy, bus.ack);
        end
        checks++;
        if (timer_data !== 8'h00 || bus.rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: td=%h rd=%h want 00 00", timer_data, bus.rdata);
        end
        checks++;
        if (set_delay !== 1'b0 || set_sound !== 1'b0 || beep !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe: sd=%b ss=%b bp=%b want 0", set_delay, set_sound, beep);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_in_wait;
        ld_d = 1'b1; ld_val = 8'd5;
        bus.req = 1'b1; bus.op = 2'b11; bus.wdata = 8'h77;
        @(negedge clk);
        ld_d = 1'b0; bus.req = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || timer_data !== 8'h77) begin
            errors++;
            $display("FAIL wait_entry: busy=%b td=%h want 1 77", bus.busy, timer_data);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold: busy=%b ack=%b want 1 0", bus.busy, bus.ack);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.ack !== 1'b0 || timer_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: busy=%b ack=%b td=%h want 0 0 00",
                     bus.busy, bus.ack, timer_data);
        end
        checks++;
        if (set_delay !== 1'b0 || set_sound !== 1'b0 || bus.rdata !== 8'h00 || beep !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_out: sd=%b ss=%b rd=%h bp=%b want 0",
                     set_delay, set_sound, bus.rdata, beep);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.ack !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_ack[%0d]: ack=%b busy=%b want 0 0", i, bus.ack, bus.busy);
            end
        end
    endtask

    task automatic test_write_delay;
        bus.req = 1'b1; bus.op = 2'b01; bus.wdata = 8'h3C;
        @(negedge clk);
        bus.req = 1'b0;
        checks++;
        if (set_delay !== 1'b1 || set_sound !== 1'b0 || timer_data !== 8'h3C) begin
            errors++;
            $display("FAIL wd_strobe: sd=%b ss=%b td=%h want 1 0 3c",
                     set_delay, set_sound, timer_data);
        end
        checks++;
        if (bus.ack !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL wd_busy: ack=%b busy=%b want 0 1", bus.ack, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || set_delay !== 1'b0 || set_sound !== 1'b0) begin
            errors++;
            $display("FAIL wd_ack: ack=%b sd=%b ss=%b want 1 0 0", bus.ack, set_delay, set_sound);
        end
        checks++;
        if (d_tmr !== 8'h3C) begin
            errors++;
            $display("FAIL wd_timer: got %h want 3c", d_tmr);
        end
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle: ack=%b busy=%b want 0 0", bus.ack, bus.busy);
        end
    endtask

    task automatic test_write_sound;
        bus.req = 1'b1; bus.op = 2'b10; bus.wdata = 8'h05;
        @(negedge clk);
        bus.req = 1'b0;
        checks++;
        if (set_sound !== 1'b1 || set_delay !== 1'b0 || timer_data !== 8'h05) begin
            errors++;
            $display("FAIL ws_strobe: ss=%b sd=%b td=%h want 1 0 05",
                     set_sound, set_delay, timer_data);
        end
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || set_sound !== 1'b0 || s_tmr !== 8'h05 || beep !== 1'b0) begin
            errors++;
            $display("FAIL ws_ack: ack=%b ss=%b st=%h bp=%b want 1 0 05 0",
                     bus.ack, set_sound, s_tmr, beep);
        end
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            checks++;
            if (beep !== 1'((i / 4) % 2)) begin
                errors++;
                $display("FAIL beep_phase[%0d]: got %b want %b", i, beep, 1'((i / 4) % 2));
            end
            if (set_sound !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL ws_extra_strobe[%0d]: got %b want 0", i, set_sound);
            end
        end
        ld_s = 1'b1; ld_val = 8'h00;
        @(negedge clk);
        ld_s = 1'b0;
        checks++;
        if (beep !== 1'b1 || s_tmr !== 8'h00) begin
            errors++;
            $display("FAIL beep_hold: bp=%b st=%h want 1 00", beep, s_tmr);
        end
        @(negedge clk);
        checks++;
        if (beep !== 1'b0) begin
            errors++;
            $display("FAIL beep_clear: got %b want 0", beep);
        end
    endtask

    task automatic test_read;
        ld_d = 1'b1; ld_val = 8'h2A;
        @(negedge clk);
        ld_d = 1'b0;
        bus.req = 1'b1; bus.op = 2'b00; bus.wdata = 8'hEE;
        @(negedge clk);
        bus.req = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.ack !== 1'b0 || set_delay !== 1'b0) begin
            errors++;
            $display("FAIL rd_busy: busy=%b ack=%b sd=%b want 1 0 0", bus.busy, bus.ack, set_delay);
        end
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.rdata !== 8'h2A) begin
            errors++;
            $display("FAIL rd_ack: ack=%b rd=%h want 1 2a", bus.ack, bus.rdata);
        end
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b0 || bus.busy !== 1'b0 || bus.rdata !== 8'h2A) begin
            errors++;
            $display("FAIL rd_hold: ack=%b busy=%b rd=%h want 0 0 2a",
                     bus.ack, bus.busy, bus.rdata);
        end
    endtask

    task automatic test_wait;
        ld_d = 1'b1; ld_val = 8'd3;
        @(negedge clk);
        ld_d = 1'b0; dec_d = 1'b1;
        bus.req = 1'b1; bus.op = 2'b11; bus.wdata = 8'h05;
        @(negedge clk);
        bus.req = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL wt_enter: busy=%b ack=%b want 1 0", bus.busy, bus.ack);
        end
        @(negedge clk);
        bus.req = 1'b1; bus.op = 2'b01; bus.wdata = 8'h99;
        checks++;
        if (bus.busy !== 1'b1 || bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL wt_mid1: busy=%b ack=%b want 1 0", bus.busy, bus.ack);
        end
        @(negedge clk);
        bus.req = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.ack !== 1'b0 || set_delay !== 1'b0) begin
            errors++;
            $display("FAIL wt_mid2: busy=%b ack=%b sd=%b want 1 0 0", bus.busy, bus.ack, set_delay);
        end
        @(negedge clk);
        checks++;
        if (bus.ack !== 1'b1 || bus.rdata !== 8'h00) begin
            errors++;
            $display("FAIL wt_ack: ack=%b rd=%h want 1 00", bus.ack, bus.rdata);
        end
        @(negedge clk);
        dec_d = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || timer_data !== 8'h05 || set_delay !== 1'b0) begin
            errors++;
            $display("FAIL wt_ignored_req: busy=%b td=%h sd=%b want 0 05 0",
                     bus.busy, timer_data, set_delay);
        end
    endtask

    task automatic test_back_to_back;
        int n_sd;
        n_sd = 0;
        bus.req = 1'b1; bus.op = 2'b01; bus.wdata = 8'h11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (set_delay === 1'b1) n_sd++;
            checks++;
            if (set_delay !== (i % 3 == 0) || bus.ack !== (i % 3 == 1)) begin
                errors++;
                $display("FAIL b2b_slot[%0d]: sd=%b ack=%b want %b %b",
                         i, set_delay, bus.ack, (i % 3 == 0), (i % 3 == 1));
            end
            checks++;
            if (set_sound !== 1'b0) begin
                errors++;
                $display("FAIL b2b_sound[%0d]: got %b want 0", i, set_sound);
            end
            if (i == 7) bus.req = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || set_delay !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b sd=%b want 0 0", bus.busy, set_delay);
        end
        checks++;
        if (n_sd != 3 || d_tmr !== 8'h11) begin
            errors++;
            $display("FAIL b2b_count: strobes=%0d dt=%h want 3 11", n_sd, d_tmr);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 1'b0; bus.op = 2'b00; bus.wdata = 8'h00;
        ld_d = 1'b0; ld_s = 1'b0; dec_d = 1'b0; ld_val = 8'h00;
        test_reset();
        test_reset_in_wait();
        test_write_delay();
        test_write_sound();
        test_read();
        test_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
